// File: rtl/bg_noise_sub.sv
// Background-noise subtractor: learns a per-lane mean over 2^LOG2_PERIODS training
// periods, then streams (sample - mean) residuals through a one-stage output register.
module bg_noise_sub #(
   parameter int LANES        = 16,
   parameter int DW           = 8,
   parameter int AW           = 16,
   parameter int LOG2_PERIODS = 3
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      start,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [LANES*DW-1:0]       in_data,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [LANES*(DW+1)-1:0]   out_data,
   output logic                      mean_valid,
   output logic                      busy
);

   typedef enum logic [1:0] {S_IDLE, S_TRAIN, S_DIVIDE, S_DETECT} state_t;

   state_t                          state_q, state_d;
   logic [LOG2_PERIODS-1:0]         cnt_q, cnt_d;
   logic signed [AW-1:0]            acc_q  [LANES];
   logic signed [AW-1:0]            acc_d  [LANES];
   logic signed [DW-1:0]            mean_q [LANES];
   logic signed [DW-1:0]            mean_d [LANES];
   logic                            out_valid_q, out_valid_d;
   logic [LANES*(DW+1)-1:0]         out_data_q, out_data_d;
   logic                            accept;

   function automatic logic signed [AW-1:0] widen(input logic signed [DW-1:0] x);
      return {{(AW-DW){x[DW-1]}}, x};
   endfunction

   function automatic logic signed [DW:0] residual(input logic signed [DW-1:0] x,
                                                  input logic signed [DW-1:0] m);
      return {x[DW-1], x} - {m[DW-1], m};
   endfunction

   always_comb begin
      in_ready = 1'b0;
      unique case (state_q)
         S_TRAIN:  in_ready = !start;
         S_DETECT: in_ready = (!out_valid_q || out_ready) && !start;
         default:  in_ready = 1'b0;
      endcase
   end

   assign accept     = in_valid && in_ready;
   assign out_valid  = out_valid_q;
   assign out_data   = out_data_q;
   assign mean_valid = (state_q == S_DETECT);
   assign busy       = (state_q == S_TRAIN) || (state_q == S_DIVIDE);

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      acc_d       = acc_q;
      mean_d      = mean_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;

      // start overrides every state; the stored mean stays until the next DIVIDE
      if (start) begin
         state_d     = S_TRAIN;
         cnt_d       = '0;
         out_valid_d = 1'b0;
         for (int unsigned i = 0; i < LANES; i++) acc_d[i] = '0;
      end else begin
         unique case (state_q)
            S_TRAIN: begin
               if (accept) begin
                  for (int unsigned i = 0; i < LANES; i++)
                     acc_d[i] = acc_q[i] + widen(in_data[DW*i +: DW]);
                  cnt_d = cnt_q + LOG2_PERIODS'(1);
                  if (cnt_q == '1) state_d = S_DIVIDE;
               end
            end
            S_DIVIDE: begin
               for (int unsigned i = 0; i < LANES; i++)
                  mean_d[i] = DW'(acc_q[i] >>> LOG2_PERIODS);
               state_d = S_DETECT;
            end
            S_DETECT: begin
               if (accept) begin
                  out_valid_d = 1'b1;
                  for (int unsigned i = 0; i < LANES; i++)
                     out_data_d[(DW+1)*i +: DW+1] = residual(in_data[DW*i +: DW], mean_q[i]);
               end else if (out_ready) begin
                  out_valid_d = 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         for (int unsigned i = 0; i < LANES; i++) begin
            acc_q[i]  <= '0;
            mean_q[i] <= '0;
         end
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         for (int unsigned i = 0; i < LANES; i++) begin
            acc_q[i]  <= acc_d[i];
            mean_q[i] <= mean_d[i];
         end
      end
   end

endmodule

// File: tb/tb_bg_noise_sub.sv
// Scoreboard bench for bg_noise_sub: the bench learns its own per-lane means from the
// training beats it drives and predicts each residual when the beat is accepted.
module tb_bg_noise_sub;

   localparam int LANES = 16;
   localparam int DW    = 8;
   localparam int AW    = 16;
   localparam int LP    = 3;
   localparam int NP    = 1 << LP;
   localparam int OW    = LANES*(DW+1);

   typedef logic [OW-1:0] vec_t;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              start = 1'b0;
   logic              in_valid = 1'b0;
   logic              in_ready;
   logic [LANES*DW-1:0] in_data = '0;
   logic              out_valid;
   logic              out_ready = 1'b0;
   logic [OW-1:0]     out_data;
   logic              mean_valid;
   logic              busy;

   int   vals    [LANES];
   int   tb_sum  [LANES];
   int   tb_mean [LANES];
   int   tb_cnt;
   bit   training;
   vec_t sb[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   bg_noise_sub #(.LANES(LANES), .DW(DW), .AW(AW), .LOG2_PERIODS(LP)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_data    (in_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .mean_valid (mean_valid),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input vec_t obs, input vec_t exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [LANES*DW-1:0] pack_in();
      logic [LANES*DW-1:0] r;
      r = '0;
      for (int i = 0; i < LANES; i++) r[DW*i +: DW] = vals[i][DW-1:0];
      return r;
   endfunction

   function automatic vec_t expect_res();
      vec_t e;
      int   r;
      e = '0;
      for (int i = 0; i < LANES; i++) begin
         r = vals[i] - tb_mean[i];
         e[(DW+1)*i +: DW+1] = r[DW:0];
      end
      return e;
   endfunction

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Drives vals as one beat and waits (bounded) for it to be accepted.
   task automatic send_beat();
      bit ok;
      in_data  = pack_in();
      in_valid = 1'b1;
      ok = 1'b0;
      for (int n = 0; n < 40 && !ok; n++) begin
         @(negedge clk);
         if (in_ready) ok = 1'b1;
      end
      if (!ok) chk("accept_timeout", vec_t'(in_ready), vec_t'(1));
      else if (training) begin
         for (int i = 0; i < LANES; i++) tb_sum[i] += vals[i];
         tb_cnt++;
         if (tb_cnt == NP) begin
            for (int i = 0; i < LANES; i++) tb_mean[i] = tb_sum[i] >>> LP;
            training = 1'b0;
         end
      end else begin
         sb.push_back(expect_res());
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic do_start(input bit with_beat);
      @(posedge clk);
      #1;
      start = 1'b1;
      if (with_beat) begin
         in_data  = pack_in();
         in_valid = 1'b1;
      end
      @(negedge clk);
      chk("start_in_ready", vec_t'(in_ready), '0);
      @(posedge clk);
      #1;
      start    = 1'b0;
      in_valid = 1'b0;
      training = 1'b1;
      tb_cnt   = 0;
      for (int i = 0; i < LANES; i++) tb_sum[i] = 0;
      sb.delete();
   endtask

   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         if (sb.size() == 0) chk("unexpected_out", vec_t'(out_valid), '0);
         else chk("residual", out_data, sb.pop_front());
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t held;
      bit   seen;
      for (int i = 0; i < LANES; i++) tb_mean[i] = 0;

      // reset values
      #3;
      chk("rst_in_ready",  vec_t'(in_ready),   '0);
      chk("rst_out_valid", vec_t'(out_valid),  '0);
      chk("rst_out_data",  out_data,           '0);
      chk("rst_mean_valid",vec_t'(mean_valid), '0);
      chk("rst_busy",      vec_t'(busy),       '0);
      #19 rst_n = 1'b1;
      step(1);
      chk("idle_in_ready", vec_t'(in_ready), '0);

      // train on +5, detect +7 -> +2
      do_start(1'b0);
      chk("train_busy", vec_t'(busy), vec_t'(1));
      for (int k = 0; k < NP; k++) begin
         for (int i = 0; i < LANES; i++) vals[i] = 5;
         send_beat();
      end
      chk("divide_busy", vec_t'(busy), vec_t'(1));
      chk("divide_mv",   vec_t'(mean_valid), '0);
      chk("divide_rdy",  vec_t'(in_ready), '0);
      step(1);
      chk("detect_mv",   vec_t'(mean_valid), vec_t'(1));
      chk("detect_busy", vec_t'(busy), '0);
      out_ready = 1'b1;
      for (int i = 0; i < LANES; i++) vals[i] = 7;
      send_beat();
      chk("latency_valid", vec_t'(out_valid), vec_t'(1));
      for (int k = 0; k < 3; k++) begin
         for (int i = 0; i < LANES; i++) vals[i] = int'($urandom_range(255)) - 128;
         send_beat();
      end
      step(3);
      chk("drain1", vec_t'(sb.size()), '0);
      chk("idle_out_valid", vec_t'(out_valid), '0);

      // negative means, 9-bit residual extremes
      do_start(1'b0);
      for (int k = 0; k < NP; k++) begin
         vals[0] = -1;
         vals[1] = (k % 2 == 0) ? 127 : -128;
         for (int i = 2; i < LANES; i++) vals[i] = k*3 - i;
         send_beat();
      end
      step(1);
      chk("mv2", vec_t'(mean_valid), vec_t'(1));
      vals[0] = -128;
      vals[1] = 127;
      for (int i = 2; i < LANES; i++) vals[i] = int'($urandom_range(255)) - 128;
      send_beat();
      vals[0] = 127;
      vals[1] = -128;
      send_beat();
      step(3);
      chk("drain2", vec_t'(sb.size()), '0);

      // backpressure: first residual held while out_ready is low
      out_ready = 1'b0;
      fork
         begin
            for (int k = 0; k < 5; k++) begin
               for (int i = 0; i < LANES; i++) vals[i] = ((k*17 + i*5) % 200) - 100;
               send_beat();
            end
         end
         begin
            seen = 1'b0;
            for (int n = 0; n < 20 && !seen; n++) begin
               @(negedge clk);
               if (out_valid) seen = 1'b1;
            end
            chk("bp_seen", vec_t'(out_valid), vec_t'(1));
            held = out_data;
            for (int j = 0; j < 3; j++) begin
               @(negedge clk);
               chk("bp_hold",  out_data, held);
               chk("bp_valid", vec_t'(out_valid), vec_t'(1));
               chk("bp_ready", vec_t'(in_ready), '0);
            end
            @(posedge clk);
            #1;
            out_ready = 1'b1;
         end
      join
      step(4);
      chk("bp_drain", vec_t'(sb.size()), '0);

      // restart after 4 beats: only the post-restart 8 beats count
      do_start(1'b0);
      for (int k = 0; k < 4; k++) begin
         for (int i = 0; i < LANES; i++) vals[i] = 100;
         send_beat();
      end
      do_start(1'b0);
      for (int k = 0; k < NP-1; k++) begin
         for (int i = 0; i < LANES; i++) vals[i] = 3;
         send_beat();
      end
      chk("restart_mv7",   vec_t'(mean_valid), '0);
      chk("restart_busy7", vec_t'(busy), vec_t'(1));
      send_beat();
      step(1);
      chk("restart_mv8", vec_t'(mean_valid), vec_t'(1));
      for (int i = 0; i < LANES; i++) vals[i] = i - 8;
      send_beat();
      for (int i = 0; i < LANES; i++) vals[i] = 3;
      send_beat();
      step(3);
      chk("drain3", vec_t'(sb.size()), '0);

      // start in DETECT with a stalled residual and a beat on the input
      out_ready = 1'b0;
      for (int i = 0; i < LANES; i++) vals[i] = 50;
      send_beat();
      chk("pre_start_valid", vec_t'(out_valid), vec_t'(1));
      for (int i = 0; i < LANES; i++) vals[i] = -60;
      do_start(1'b1);
      chk("ds_out_valid", vec_t'(out_valid), '0);
      chk("ds_mean_valid",vec_t'(mean_valid), '0);
      chk("ds_busy",      vec_t'(busy), vec_t'(1));
      out_ready = 1'b1;
      for (int k = 0; k < NP; k++) begin
         for (int i = 0; i < LANES; i++) vals[i] = -3 - (i % 2);
         send_beat();
      end
      step(1);
      for (int i = 0; i < LANES; i++) vals[i] = 0;
      send_beat();
      step(3);
      chk("drain4", vec_t'(sb.size()), '0);

      // asynchronous reset mid-training
      do_start(1'b0);
      for (int k = 0; k < 3; k++) begin
         for (int i = 0; i < LANES; i++) vals[i] = 9;
         send_beat();
      end
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_busy",      vec_t'(busy), '0);
      chk("arst_in_ready",  vec_t'(in_ready), '0);
      chk("arst_mean_valid",vec_t'(mean_valid), '0);
      chk("arst_out_valid", vec_t'(out_valid), '0);
      chk("arst_out_data",  out_data, '0);
      #10 rst_n = 1'b1;
      in_valid = 1'b1;
      for (int j = 0; j < 3; j++) begin
         @(negedge clk);
         chk("post_rst_ready", vec_t'(in_ready), '0);
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      do_start(1'b0);
      chk("post_rst_busy", vec_t'(busy), vec_t'(1));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
